// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB write arbiter.
// Contents: FSM state encodings, SCCB device id, COM7 soft-reset write value,
// default timing constants and a small max helper used for counter sizing.
package sccb_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StGuard  = 3'd0;
  localparam state_t StIdle   = 3'd1;
  localparam state_t StSend   = 3'd2;
  localparam state_t StWait   = 3'd3;
  localparam state_t StSettle = 3'd4;

  localparam logic [7:0]  SCCB_ID    = 8'h42;
  localparam logic [15:0] COM7_RESET = 16'h1280;

  localparam int unsigned DEF_NUM_REQ       = 4;
  localparam int unsigned DEF_XFER_CYCLES   = 8448;
  localparam int unsigned DEF_TAKEN_TIMEOUT = 16384;
  localparam int unsigned DEF_SETTLE_CYCLES = 50000;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sccb_rr_picker.sv
// Combinational requester picker: index 0 has absolute priority, the rest are
// served round-robin starting at rr_ptr (which is always in 1..NUM_REQ-1).
// Ports:
//   req     in   NUM_REQ  live request levels
//   rr_ptr  in   IDX_W    first index of the round-robin search
//   winner  out  IDX_W    chosen requester (only meaningful when valid)
//   valid   out  1        at least one request is asserted
module sccb_rr_picker
  import sccb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  logic              found;
  int unsigned       idx;
  logic [IDX_W-1:0]  cand;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    cand   = '0;
    if (req[0]) begin
      found = 1'b1;
    end
    for (int unsigned k = 0; k < NUM_REQ - 1; k++) begin
      // (rr_ptr - 1 + k) mod (NUM_REQ - 1), kept non-negative, mapped back to 1..NUM_REQ-1
      idx  = ((32'(rr_ptr) + NUM_REQ - 2 + k) % (NUM_REQ - 1)) + 1;
      cand = IDX_W'(idx);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
    valid = |req;
  end

endmodule

// File: rtl/sccb_write_arbiter.sv
// Shares one SCCB write engine (i2c_sender) among NUM_REQ register-write requesters.
// Requester 0 (power-up sequencer) has absolute priority; the others are round-robin.
// Each write is latched, handed to the engine with send, and timed from taken to
// completion, after which done (or err on taken timeout) pulses to the issuer.
// Optional feature macro: SCCB_ARB_SETTLE_EN -- after a COM7 soft-reset write
// (0x12/0x80) hold busy for SETTLE_CYCLES more before reporting done.
// Ports:
//   clk_50     in   system clock
//   rst_n      in   synchronous active-low reset
//   req        in   per-requester request level, held until gnt
//   req_addr   in   register address, slice i = [8i+7:8i]
//   req_data   in   register value, same slicing
//   gnt        out  1-cycle pulse: request latched
//   done       out  1-cycle pulse: write finished
//   err        out  1-cycle pulse: write aborted (no taken)
//   busy       out  high in every state except idle
//   send       out  to i2c_sender.send
//   reg_addr   out  to i2c_sender.data
//   reg_value  out  to i2c_sender.value
//   taken      in   from i2c_sender.taken
module sccb_write_arbiter
  import sccb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = DEF_NUM_REQ,
  parameter int unsigned XFER_CYCLES   = DEF_XFER_CYCLES,
  parameter int unsigned TAKEN_TIMEOUT = DEF_TAKEN_TIMEOUT,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                 clk_50,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [NUM_REQ-1:0]   err,
  output logic                 busy,
  output logic                 send,
  output logic [7:0]           reg_addr,
  output logic [7:0]           reg_value,
  input  logic                 taken
);

  localparam int unsigned IDX_W   = $clog2(NUM_REQ);
  localparam int unsigned CNT_MAX = max3(XFER_CYCLES, TAKEN_TIMEOUT, SETTLE_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   rr_next;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [7:0]         pick_addr;
  logic [7:0]         pick_data;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  sccb_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  assign pick_addr = req_addr[{pick_idx, 3'b000} +: 8];
  assign pick_data = req_data[{pick_idx, 3'b000} +: 8];
  assign rr_next   = (32'(win) == NUM_REQ - 1) ? IDX_W'(1) : win + IDX_W'(1);
  assign busy      = (state != StIdle);

  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      state     <= StGuard;
      cnt       <= CNT_W'(XFER_CYCLES - 1);
      rr_ptr    <= IDX_W'(1);
      win       <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= '0;
      send      <= 1'b0;
      reg_addr  <= '0;
      reg_value <= '0;
    end else begin
      gnt  <= '0;
      done <= '0;
      err  <= '0;
      unique case (state)
        // The engine has no reset: let any transfer it was running drain first.
        StGuard: begin
          if (cnt == '0) state <= StIdle;
          else           cnt   <= cnt - CNT_W'(1);
        end
        StIdle: begin
          if (pick_valid) begin
            win       <= pick_idx;
            gnt       <= onehot(pick_idx);
            reg_addr  <= pick_addr;
            reg_value <= pick_data;
            send      <= 1'b1;
            cnt       <= CNT_W'(TAKEN_TIMEOUT - 1);
            state     <= StSend;
          end
        end
        StSend: begin
          // Drop send on the taken edge so the engine does not re-trigger.
          if (taken) begin
            send  <= 1'b0;
            cnt   <= CNT_W'(XFER_CYCLES - 1);
            state <= StWait;
          end else if (cnt == '0) begin
            send  <= 1'b0;
            err   <= onehot(win);
            state <= StIdle;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        StWait: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end
`ifdef SCCB_ARB_SETTLE_EN
          else if ({reg_addr, reg_value} == COM7_RESET) begin
            cnt   <= CNT_W'(SETTLE_CYCLES - 1);
            state <= StSettle;
          end
`endif
          else begin
            done  <= onehot(win);
            state <= StIdle;
            if (win != '0) rr_ptr <= rr_next;
          end
        end
`ifdef SCCB_ARB_SETTLE_EN
        StSettle: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            done  <= onehot(win);
            state <= StIdle;
            if (win != '0) rr_ptr <= rr_next;
          end
        end
`endif
        default: begin
          send  <= 1'b0;
          cnt   <= CNT_W'(XFER_CYCLES - 1);
          state <= StGuard;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_write_arbiter.sv
// Directed testbench for sccb_write_arbiter with a behavioural i2c_sender model
// (taken pulses TK_DLY cycles after send rises). Timing constants are scaled down.
module tb_sccb_write_arbiter;

  localparam int NREQ   = 4;
  localparam int XFER   = 64;
  localparam int TOUT   = 100;
  localparam int SETTLE = 200;
  localparam int TK_DLY = 6;

  logic            clk_50 = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic [7:0]      addr_a [NREQ];
  logic [7:0]      data_a [NREQ];
  logic [8*NREQ-1:0] req_addr, req_data;
  logic [NREQ-1:0] gnt, done, err;
  logic            busy, send, taken;
  logic [7:0]      reg_addr, reg_value;

  logic            model_en;
  int              send_age;
  logic            send_prev;
  int              cyc, send_bursts, done_total, overlap;
  int              gnt_q[$];
  int              n_checks, n_errors;

  assign req_addr = {addr_a[3], addr_a[2], addr_a[1], addr_a[0]};
  assign req_data = {data_a[3], data_a[2], data_a[1], data_a[0]};

  always #5 clk_50 = ~clk_50;

  sccb_write_arbiter #(
    .NUM_REQ       (NREQ),
    .XFER_CYCLES   (XFER),
    .TAKEN_TIMEOUT (TOUT),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk_50    (clk_50),
    .rst_n     (rst_n),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .send      (send),
    .reg_addr  (reg_addr),
    .reg_value (reg_value),
    .taken     (taken)
  );

  // Engine model: one taken pulse per send burst, TK_DLY cycles after send rises.
  initial begin
    taken    = 1'b0;
    send_age = 0;
  end
  always @(posedge clk_50) begin
    cyc <= cyc + 1;
    taken <= (send && model_en && send_age == TK_DLY - 1);
    send_age <= send ? send_age + 1 : 0;
  end

  initial begin
    cyc = 0; send_prev = 1'b0; send_bursts = 0; done_total = 0; overlap = 0;
  end
  always @(negedge clk_50) begin
    send_prev <= send;
    if (send && !send_prev) send_bursts <= send_bursts + 1;
    if (|done) done_total <= done_total + 1;
    if (|done && |gnt) overlap <= overlap + 1;
    if (|gnt) gnt_q.push_back(first_set(gnt));
  end

  function automatic int first_set(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = NREQ - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // which: 0 gnt, 1 done, 2 err, 3 taken. idx/at = -1 if the budget expires.
  // idle counts sampled cycles with busy low and no pulse seen yet.
  task automatic wait_pulse(input int which, input int budget,
                            output int idx, output int at, output int idle);
    logic [NREQ-1:0] v;
    idx = -1; at = -1; idle = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_50);
      case (which)
        0:       v = gnt;
        1:       v = done;
        2:       v = err;
        default: v = {{(NREQ-1){1'b0}}, taken};
      endcase
      if (|v) begin
        idx = first_set(v);
        at  = cyc;
        break;
      end
      if (!busy) idle++;
    end
  endtask

  int idx, at, idle, tk, rel, g, d, e, b0, dt, exp6;
  int exp2 [4] = '{2, 3, 1, 2};

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; req = '0; model_en = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      addr_a[i] = '0; data_a[i] = '0;
    end

    // 1: reset values, guard window, first write
    req[1] = 1'b1; addr_a[1] = 8'h55; data_a[1] = 8'h40;
    repeat (3) @(negedge clk_50);
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_send", send, 0);
    check("rst_addr", reg_addr, 0);
    check("rst_value", reg_value, 0);
    check("rst_busy", busy, 1);
    rst_n = 1'b1; rel = cyc;
    wait_pulse(0, 200, idx, at, idle);
    check("t1_gnt_idx", idx, 1);
    check("t1_guard_len", at - rel, XFER + 1);
    check("t1_addr", reg_addr, 8'h55);
    check("t1_value", reg_value, 8'h40);
    check("t1_send", send, 1);
    req[1] = 1'b0;
    wait_pulse(3, 50, idx, tk, idle);
    wait_pulse(1, 200, idx, at, idle);
    check("t1_done_idx", idx, 1);
    check("t1_done_lat", at - tk, XFER + 1);
    check("t1_busy_at_done", busy, 0);
    check("t1_bursts", send_bursts, 1);

    // 2: three requesters held; rr_ptr is 2 after the done from requester 1
    b0 = send_bursts; gnt_q.delete();
    addr_a[1] = 8'h11; addr_a[2] = 8'h22; addr_a[3] = 8'h33;
    data_a[1] = 8'hA1; data_a[2] = 8'hA2; data_a[3] = 8'hA3;
    req = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      wait_pulse(1, 300, idx, at, idle);
      check("t2_done_idx", idx, exp2[i]);
    end
    req = '0;
    for (int i = 0; i < 4; i++) check("t2_gnt_order", (i < gnt_q.size()) ? gnt_q[i] : -1, exp2[i]);
    check("t2_bursts", send_bursts - b0, 4);
    check("t2_last_addr", reg_addr, 8'h22);
    check("t2_last_value", reg_value, 8'hA2);

    // 3: requester 0 beats a pending requester 3; rr_ptr is 3 here
    req = 4'b0100;
    wait_pulse(0, 50, idx, at, idle);
    check("t3_gnt_first", idx, 2);
    req[2] = 1'b0; req[3] = 1'b1;
    wait_pulse(3, 50, idx, tk, idle);
    req[0] = 1'b1;
    wait_pulse(1, 200, idx, d, idle);
    check("t3_done_2", idx, 2);
    wait_pulse(0, 50, idx, g, idle);
    check("t3_gnt_0", idx, 0);
    check("t3_idle_gap", g - d, 1);
    req[0] = 1'b0;
    wait_pulse(1, 200, idx, at, idle);
    check("t3_done_0", idx, 0);
    wait_pulse(0, 50, idx, at, idle);
    check("t3_gnt_3", idx, 3);
    req[3] = 1'b0;
    wait_pulse(1, 200, idx, at, idle);
    check("t3_done_3", idx, 3);

    // 4: engine never takes -> err after exactly TOUT cycles, next request served
    model_en = 1'b0;
    req[1] = 1'b1;
    wait_pulse(0, 50, idx, g, idle);
    check("t4_gnt", idx, 1);
    req[1] = 1'b0; req[2] = 1'b1;
    wait_pulse(2, 300, idx, e, idle);
    check("t4_err_idx", idx, 1);
    check("t4_err_lat", e - g, TOUT);
    check("t4_send_low", send, 0);
    model_en = 1'b1;
    wait_pulse(0, 50, idx, at, idle);
    check("t4_next_gnt", idx, 2);
    check("t4_next_gap", at - e, 1);
    req[2] = 1'b0;
    wait_pulse(1, 200, idx, at, idle);
    check("t4_done_2", idx, 2);

    // 5: one-cycle reset mid-WAIT drops the winner and reruns the guard
    req[3] = 1'b1;
    wait_pulse(0, 50, idx, at, idle);
    check("t5_gnt", idx, 3);
    req[3] = 1'b0;
    wait_pulse(3, 50, idx, tk, idle);
    repeat (5) @(negedge clk_50);
    dt = done_total;
    rst_n = 1'b0; req[1] = 1'b1; addr_a[1] = 8'h5A; data_a[1] = 8'h01;
    @(negedge clk_50);
    check("t5_rst_gnt", gnt, 0);
    check("t5_rst_send", send, 0);
    check("t5_rst_addr", reg_addr, 0);
    check("t5_rst_busy", busy, 1);
    rst_n = 1'b1; rel = cyc;
    wait_pulse(0, 200, idx, at, idle);
    check("t5_gnt_after", idx, 1);
    check("t5_guard_len", at - rel, XFER + 1);
    check("t5_no_done", done_total - dt, 0);
    req[1] = 1'b0;
    wait_pulse(1, 200, idx, at, idle);
    check("t5_done_1", idx, 1);

    // 6: COM7 soft-reset write
    addr_a[1] = 8'h12; data_a[1] = 8'h80; req[1] = 1'b1;
    wait_pulse(0, 50, idx, at, idle);
    check("t6_gnt", idx, 1);
    req[1] = 1'b0;
    wait_pulse(3, 50, idx, tk, idle);
`ifdef SCCB_ARB_SETTLE_EN
    exp6 = XFER + 1 + SETTLE;
`else
    exp6 = XFER + 1;
`endif
    wait_pulse(1, 600, idx, at, idle);
    check("t6_done_idx", idx, 1);
    check("t6_done_lat", at - tk, exp6);
    check("t6_busy_held", idle, 0);

    check("no_done_gnt_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
